// File: rtl/uart_rxr.sv
// UART receiver, 8N1 LSB first. Mid-bit sampling from a per-bit clock counter,
// valid/ack byte handshake, framing-error and overrun pulses.
module uart_rxr #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_serial,
    input  logic       i_byte_ack,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned H  = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] CNT_HALF = CW'(H);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StCleanup} state_e;

    state_e        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          cnt_half, cnt_last, stop_good, stop_bad;

    assign cnt_half = (cnt_q == CNT_HALF);
    assign cnt_last = (cnt_q == CNT_LAST);

    // Idle-high reset value keeps a released reset from looking like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx_serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (!rx_s_q) state_d = StStart;
            StStart:   if (cnt_half) state_d = rx_s_q ? StIdle : StData;
            StData:    if (cnt_last && idx_q == 3'd7) state_d = StStop;
            StStop:    if (cnt_last) state_d = StCleanup;
            StCleanup: if (rx_s_q) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        o_busy    = (state_q != StIdle);
        cnt_d     = '0;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            StStart: begin
                if (cnt_half) begin
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_last) begin
                    shreg_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_last) begin
                    stop_good = rx_s_q;
                    stop_bad  = !rx_s_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        byte_d      = byte_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;
        // An ack coinciding with a completing byte is absorbed: the new byte stays valid.
        if (stop_good) begin
            byte_d    = shreg_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !i_byte_ack;
        end else if (valid_q && i_byte_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'h00;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = valid_q;
    assign o_frame_err  = frame_err_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rxr.sv
// Self-checking bench for uart_rxr: directed scenarios plus random frames scored
// against a byte-level model of the valid/ack/overrun/frame-error rules.
module tb_uart_rxr;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ack;
    logic [7:0] dout;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    uart_rxr #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_serial  (rx),
        .i_byte_ack   (ack),
        .o_byte       (dout),
        .o_byte_valid (valid),
        .o_frame_err  (ferr),
        .o_overrun    (ovr),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;

    // Byte-level reference state.
    bit         model_valid = 1'b0;
    logic [7:0] model_byte  = 8'h00;
    int         model_ov    = 0;
    int         model_fe    = 0;

    always @(negedge clk) begin
        if (ferr) fe_cnt <= fe_cnt + 1;
        if (ovr)  ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop-bit decision lands on the posedge after the 10th stop-bit negedge,
    // so ack_end covers exactly the completing cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic ack_start, input logic ack_end);
        rx  = 1'b0;
        ack = ack_start;
        wait_cycles(1);
        ack = 1'b0;
        wait_cycles(CPB - 1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(10);
        ack = ack_end;
        wait_cycles(1);
        ack = 1'b0;
        wait_cycles(CPB - 11);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic ack_start, input logic ack_end);
        if (ack_start) model_valid = 1'b0;
        send_frame(b, 1'b1, ack_start, ack_end);
        if (model_valid && !ack_end) model_ov++;
        model_valid = 1'b1;
        model_byte  = b;
        check("byte",      32'(dout),  32'(model_byte));
        check("valid",     32'(valid), 32'(model_valid));
        check("overruns",  32'(ov_cnt), 32'(model_ov));
        check("frame_errs", 32'(fe_cnt), 32'(model_fe));
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] part;
        rx    = 1'b1;
        ack   = 1'b0;
        rst_n = 1'b0;
        wait_cycles(3);
        check("rst_byte",  32'(dout),  32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr",  32'(ferr),  32'h0);
        check("rst_ovr",   32'(ovr),   32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        rst_n = 1'b1;
        wait_cycles(2 * CPB);

        // Single byte held without ack.
        run_frame(8'hA5, 1'b0, 1'b0);
        check("idle_busy", 32'(busy), 32'h0);

        // Back-to-back with acks, then without.
        run_frame(8'h3C, 1'b1, 1'b0);
        run_frame(8'hC3, 1'b1, 1'b0);
        run_frame(8'h3C, 1'b1, 1'b0);
        run_frame(8'hC3, 1'b0, 1'b0);

        // Ack coinciding with completion: no overrun.
        run_frame(8'h96, 1'b0, 1'b1);

        // Glitch on the idle line.
        ack = 1'b1;
        wait_cycles(1);
        ack = 1'b0;
        model_valid = 1'b0;
        rx = 1'b0;
        wait_cycles(5);
        rx = 1'b1;
        wait_cycles(3 * CPB);
        check("glitch_valid", 32'(valid), 32'h0);
        check("glitch_ferr",  32'(fe_cnt), 32'(model_fe));
        check("glitch_busy",  32'(busy),  32'h0);
        run_frame(8'h55, 1'b0, 1'b0);

        // Bad stop bit.
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        model_fe++;
        rx = 1'b1;
        wait_cycles(CPB);
        check("ferr_count", 32'(fe_cnt), 32'(model_fe));
        check("ferr_byte",  32'(dout),   32'(model_byte));
        check("ferr_valid", 32'(valid),  32'(model_valid));

        // Break: one framing error only.
        rx = 1'b0;
        wait_cycles(40 * CPB);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        model_fe++;
        check("break_ferr",  32'(fe_cnt), 32'(model_fe));
        check("break_busy",  32'(busy),   32'h0);
        check("break_valid", 32'(valid),  32'(model_valid));

        // Reset during bit 4.
        part = 8'h81;
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            wait_cycles(CPB);
        end
        rx = part[4];
        wait_cycles(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_byte",  32'(dout),  32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_busy",  32'(busy),  32'h0);
        check("mid_rst_ferr",  32'(ferr),  32'h0);
        check("mid_rst_ovr",   32'(ovr),   32'h0);
        wait_cycles(1);
        rx = 1'b1;
        wait_cycles(2);
        rst_n = 1'b1;
        model_valid = 1'b0;
        model_byte  = 8'h00;
        wait_cycles(2 * CPB);
        check("post_rst_ferr", 32'(fe_cnt), 32'(model_fe));
        run_frame(8'h81, 1'b0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            run_frame(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            wait_cycles(int'($urandom_range(0, 2)) * CPB);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
